// File: rtl/hqm_rcfwl_gclk_mc_clkgate_seq.sv
`default_nettype none
// ============================================================================
// Module   : hqm_rcfwl_gclk_mc_clkgate_seq
// Purpose  : Sequences the clock-gate enable of the memory-controller clock
//            distribution branch (mcckpredop) so that the gate only opens and
//            closes on PLL sync boundaries. The block waits for PLL lock,
//            counts SETTLE_CNT settling sync pulses, then opens the gate on
//            the following sync pulse. It closes the gate on the first sync
//            pulse after the request is withdrawn. Missing sync pulses or a
//            loss of lock force the gate closed and raise a sticky fault.
//
// Ports    : clk              spine clock, all logic on the rising edge
//            rst_b            asynchronous active-low reset
//            pll_sync_in      single-cycle PLL sync pulse (clk domain)
//            pll_lock         PLL lock level (already synchronised)
//            mc_clk_req       level request for the MC clock to run
//            err_clr          single-cycle pulse clearing mc_sync_err
//            fscan_clk_force  scan force of the enable (optional, see below)
//            mc_clk_en        clock-gate enable for the MC branch
//            mc_clk_ack       four-phase handshake acknowledge
//            mc_sync_err      sticky sync-timeout / lock-loss flag
//            seq_state        encoded FSM state (debug)
//
// Options  : HQM_RCFWL_MC_CLKGATE_FORCE_EN - when defined, adds the
//            fscan_clk_force input which ORs into mc_clk_en combinationally.
//
// Revision : 1.0 - initial release
// ============================================================================
module hqm_rcfwl_gclk_mc_clkgate_seq #(
    parameter int SETTLE_CNT = 4,   // sync pulses after lock before enable (1..15)
    parameter int SYNC_TMO   = 64,  // clk cycles without sync that flag a fault (2..255)
    parameter int GATE_DLY   = 2    // cycles from enable falling to ack falling (0..7)
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       pll_sync_in,
    input  logic       pll_lock,
    input  logic       mc_clk_req,
    input  logic       err_clr,
`ifdef HQM_RCFWL_MC_CLKGATE_FORCE_EN
    input  logic       fscan_clk_force,
`endif
    output logic       mc_clk_en,
    output logic       mc_clk_ack,
    output logic       mc_sync_err,
    output logic [2:0] seq_state
);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] c_ST_ALIGN     = 3'd2;
    localparam logic [2:0] c_ST_EN_PEND   = 3'd3;
    localparam logic [2:0] c_ST_ON        = 3'd4;
    localparam logic [2:0] c_ST_DRAIN     = 3'd5;

    localparam logic [3:0] c_SETTLE   = 4'(SETTLE_CNT);
    localparam logic [7:0] c_TMO_LAST = 8'(SYNC_TMO - 1);
    localparam logic [3:0] c_GATE_DLY = 4'(GATE_DLY);

    logic [2:0] r_state;
    logic       r_clk_en;
    logic       r_clk_ack;
    logic       r_sync_err;
    logic [3:0] r_settle_cnt;
    logic [7:0] r_tmo_cnt;
    logic [2:0] r_gate_cnt;

    logic [2:0] w_state;
    logic       w_clk_en;
    logic       w_clk_ack;
    logic       w_sync_err;
    logic [3:0] w_settle_cnt;
    logic [7:0] w_tmo_cnt;
    logic [2:0] w_gate_cnt;

    logic       w_sync_watch;
    logic       w_lock_watch;
    logic       w_fault;
    logic       w_gate_done;

    // Sync pulses are only expected while the branch is being aligned or is
    // running; lock is additionally required while draining.
    assign w_sync_watch = (r_state == c_ST_ALIGN) || (r_state == c_ST_EN_PEND) ||
                          (r_state == c_ST_ON);
    assign w_lock_watch = w_sync_watch || (r_state == c_ST_DRAIN);

    // A fault fires on the edge the timeout counter would reach SYNC_TMO.
    assign w_fault = (w_sync_watch && !pll_sync_in && (r_tmo_cnt == c_TMO_LAST)) ||
                     (w_lock_watch && !pll_lock);

    // Delay phase of DRAIN is finished once GATE_DLY cycles have elapsed
    // since the enable fell.
    assign w_gate_done = (({1'b0, r_gate_cnt} + 4'd1) >= c_GATE_DLY);

    always_comb begin
        w_state      = r_state;
        w_clk_en     = r_clk_en;
        w_clk_ack    = r_clk_ack;
        w_sync_err   = r_sync_err;
        w_settle_cnt = r_settle_cnt;
        w_tmo_cnt    = r_tmo_cnt;
        w_gate_cnt   = r_gate_cnt;

        if (err_clr) begin
            w_sync_err = 1'b0;
        end

        // Sync watchdog: restarts on every pulse, saturates, idle elsewhere.
        if (!w_sync_watch || pll_sync_in) begin
            w_tmo_cnt = 8'd0;
        end else if (r_tmo_cnt != 8'hFF) begin
            w_tmo_cnt = r_tmo_cnt + 8'd1;
        end

        case (r_state)
            c_ST_IDLE: begin
                if (mc_clk_req) begin
                    w_state = c_ST_WAIT_LOCK;
                end
            end
            c_ST_WAIT_LOCK: begin
                if (!mc_clk_req) begin
                    w_state = c_ST_IDLE;
                end else if (pll_lock) begin
                    w_state      = c_ST_ALIGN;
                    w_settle_cnt = 4'd0;
                end
            end
            c_ST_ALIGN: begin
                if (!mc_clk_req) begin
                    w_state = c_ST_IDLE;
                end else if (pll_sync_in) begin
                    if (r_settle_cnt != 4'hF) begin
                        w_settle_cnt = r_settle_cnt + 4'd1;
                    end
                    // The completing pulse is consumed here; EN_PEND waits
                    // for a fresh one.
                    if (w_settle_cnt == c_SETTLE) begin
                        w_state = c_ST_EN_PEND;
                    end
                end
            end
            c_ST_EN_PEND: begin
                if (!mc_clk_req) begin
                    w_state = c_ST_IDLE;
                end else if (pll_sync_in) begin
                    w_state   = c_ST_ON;
                    w_clk_en  = 1'b1;
                    w_clk_ack = 1'b1;
                end
            end
            c_ST_ON, c_ST_DRAIN: begin
                if ((r_state == c_ST_DRAIN) || !mc_clk_req) begin
                    w_state = c_ST_DRAIN;
                    if (r_clk_en) begin
                        // Enable closes only on a sync boundary, which may be
                        // the very cycle the request drops.
                        if (pll_sync_in) begin
                            w_clk_en   = 1'b0;
                            w_gate_cnt = 3'd0;
                            if (c_GATE_DLY == 4'd0) begin
                                w_clk_ack = 1'b0;
                                w_state   = c_ST_IDLE;
                            end
                        end
                    end else if (w_gate_done) begin
                        w_clk_ack = 1'b0;
                        w_state   = c_ST_IDLE;
                    end else begin
                        w_gate_cnt = r_gate_cnt + 3'd1;
                    end
                end
            end
            default: begin
                w_state = c_ST_IDLE;
            end
        endcase

        // Fault overrides everything, including a coincident err_clr.
        if (w_fault) begin
            w_state      = c_ST_WAIT_LOCK;
            w_clk_en     = 1'b0;
            w_clk_ack    = 1'b0;
            w_sync_err   = 1'b1;
            w_settle_cnt = 4'd0;
            w_tmo_cnt    = 8'd0;
            w_gate_cnt   = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state      <= c_ST_IDLE;
            r_clk_en     <= 1'b0;
            r_clk_ack    <= 1'b0;
            r_sync_err   <= 1'b0;
            r_settle_cnt <= 4'd0;
            r_tmo_cnt    <= 8'd0;
            r_gate_cnt   <= 3'd0;
        end else begin
            r_state      <= w_state;
            r_clk_en     <= w_clk_en;
            r_clk_ack    <= w_clk_ack;
            r_sync_err   <= w_sync_err;
            r_settle_cnt <= w_settle_cnt;
            r_tmo_cnt    <= w_tmo_cnt;
            r_gate_cnt   <= w_gate_cnt;
        end
    end

`ifdef HQM_RCFWL_MC_CLKGATE_FORCE_EN
    // Scan force bypasses the sequencer; a fault does not close a forced gate.
    assign mc_clk_en = r_clk_en | fscan_clk_force;
`else
    assign mc_clk_en = r_clk_en;
`endif
    assign mc_clk_ack  = r_clk_ack;
    assign mc_sync_err = r_sync_err;
    assign seq_state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_hqm_rcfwl_gclk_mc_clkgate_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_hqm_rcfwl_gclk_mc_clkgate_seq
// Purpose  : Directed self-checking bench for the MC clock-gate sequencer.
//            Observed vector is {mc_clk_en, mc_clk_ack, mc_sync_err,
//            seq_state[2:0]}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hqm_rcfwl_gclk_mc_clkgate_seq;

    logic       clk;
    logic       rst_b;
    logic       pll_sync_in;
    logic       pll_lock;
    logic       mc_clk_req;
    logic       err_clr;
`ifdef HQM_RCFWL_MC_CLKGATE_FORCE_EN
    logic       fscan_clk_force;
`endif
    logic       mc_clk_en;
    logic       mc_clk_ack;
    logic       mc_sync_err;
    logic [2:0] seq_state;

    int checks;
    int errors;

    wire [5:0] w_obs = {mc_clk_en, mc_clk_ack, mc_sync_err, seq_state};

    hqm_rcfwl_gclk_mc_clkgate_seq #(
        .SETTLE_CNT (4),
        .SYNC_TMO   (64),
        .GATE_DLY   (2)
    ) u_dut (
        .clk             (clk),
        .rst_b           (rst_b),
        .pll_sync_in     (pll_sync_in),
        .pll_lock        (pll_lock),
        .mc_clk_req      (mc_clk_req),
        .err_clr         (err_clr),
`ifdef HQM_RCFWL_MC_CLKGATE_FORCE_EN
        .fscan_clk_force (fscan_clk_force),
`endif
        .mc_clk_en       (mc_clk_en),
        .mc_clk_ack      (mc_clk_ack),
        .mc_sync_err     (mc_sync_err),
        .seq_state       (seq_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle sync pulse sampled on the next edge.
    task automatic pulse();
        pll_sync_in = 1'b1;
        step();
        pll_sync_in = 1'b0;
    endtask

    task automatic pulses(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            repeat (gap) step();
            pulse();
        end
    endtask

    // From IDLE with lock held: request and run through the full settle.
    task automatic seq_on();
        mc_clk_req = 1'b1;
        step();
        step();
        pulses(5, 7);
    endtask

    task automatic test_reset();
        rst_b       = 1'b1;
        pll_sync_in = 1'b0;
        pll_lock    = 1'b1;
        mc_clk_req  = 1'b0;
        err_clr     = 1'b0;
`ifdef HQM_RCFWL_MC_CLKGATE_FORCE_EN
        fscan_clk_force = 1'b0;
`endif
        #1 rst_b = 1'b0;
        #1;
        checks++;
        if (w_obs !== 6'b000000) begin
            errors++;
            $display("FAIL reset_async: got %b want %b", w_obs, 6'b000000);
        end
        step();
        step();
        checks++;
        if (w_obs !== 6'b000000) begin
            errors++;
            $display("FAIL reset_hold: got %b want %b", w_obs, 6'b000000);
        end
        rst_b = 1'b1;
        step();
        checks++;
        if (w_obs !== 6'b000000) begin
            errors++;
            $display("FAIL reset_release_idle: got %b want %b", w_obs, 6'b000000);
        end
    endtask

    task automatic test_enable();
        mc_clk_req = 1'b1;
        step();
        checks++;
        if (w_obs !== 6'b000001) begin
            errors++;
            $display("FAIL en_wait_lock: got %b want %b", w_obs, 6'b000001);
        end
        step();
        checks++;
        if (w_obs !== 6'b000010) begin
            errors++;
            $display("FAIL en_align: got %b want %b", w_obs, 6'b000010);
        end
        for (int k = 1; k <= 5; k++) begin
            repeat (7) step();
            pulse();
            if (k <= 3) begin
                checks++;
                if (w_obs !== 6'b000010) begin
                    errors++;
                    $display("FAIL en_settle_%0d: got %b want %b", k, w_obs, 6'b000010);
                end
            end else if (k == 4) begin
                checks++;
                if (w_obs !== 6'b000011) begin
                    errors++;
                    $display("FAIL en_pend: got %b want %b", w_obs, 6'b000011);
                end
            end else begin
                checks++;
                if (w_obs !== 6'b110100) begin
                    errors++;
                    $display("FAIL en_on_5th_pulse: got %b want %b", w_obs, 6'b110100);
                end
            end
        end
    endtask

    task automatic test_disable();
        repeat (3) step();
        mc_clk_req = 1'b0;
        step();
        checks++;
        if (w_obs !== 6'b110101) begin
            errors++;
            $display("FAIL dis_drain_entry: got %b want %b", w_obs, 6'b110101);
        end
        step();
        step();
        checks++;
        if (w_obs !== 6'b110101) begin
            errors++;
            $display("FAIL dis_wait_sync: got %b want %b", w_obs, 6'b110101);
        end
        pulse();
        checks++;
        if (w_obs !== 6'b010101) begin
            errors++;
            $display("FAIL dis_en_fall: got %b want %b", w_obs, 6'b010101);
        end
        step();
        checks++;
        if (w_obs !== 6'b010101) begin
            errors++;
            $display("FAIL dis_ack_hold: got %b want %b", w_obs, 6'b010101);
        end
        step();
        checks++;
        if (w_obs !== 6'b000000) begin
            errors++;
            $display("FAIL dis_ack_fall: got %b want %b", w_obs, 6'b000000);
        end
    endtask

    task automatic test_timeout();
        seq_on();
        repeat (63) step();
        checks++;
        if (w_obs !== 6'b110100) begin
            errors++;
            $display("FAIL tmo_before: got %b want %b", w_obs, 6'b110100);
        end
        step();
        checks++;
        if (w_obs !== 6'b001001) begin
            errors++;
            $display("FAIL tmo_fault: got %b want %b", w_obs, 6'b001001);
        end
        step();
        checks++;
        if (w_obs !== 6'b001010) begin
            errors++;
            $display("FAIL tmo_realign: got %b want %b", w_obs, 6'b001010);
        end
        pulses(4, 7);
        checks++;
        if (w_obs !== 6'b001011) begin
            errors++;
            $display("FAIL tmo_pend: got %b want %b", w_obs, 6'b001011);
        end
        pulses(1, 7);
        checks++;
        if (w_obs !== 6'b111100) begin
            errors++;
            $display("FAIL tmo_reenable: got %b want %b", w_obs, 6'b111100);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++;
        if (w_obs !== 6'b110100) begin
            errors++;
            $display("FAIL tmo_err_clr: got %b want %b", w_obs, 6'b110100);
        end
    endtask

    task automatic test_lock_loss();
        // err_clr coincides with the fault: the fault must win.
        pll_lock = 1'b0;
        err_clr  = 1'b1;
        step();
        pll_lock = 1'b1;
        err_clr  = 1'b0;
        checks++;
        if (w_obs !== 6'b001001) begin
            errors++;
            $display("FAIL lock_loss_fault: got %b want %b", w_obs, 6'b001001);
        end
    endtask

    task automatic test_withdraw();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++;
        if (w_obs !== 6'b000010) begin
            errors++;
            $display("FAIL wd_align_clr: got %b want %b", w_obs, 6'b000010);
        end
        pulses(2, 7);
        checks++;
        if (w_obs !== 6'b000010) begin
            errors++;
            $display("FAIL wd_two_pulses: got %b want %b", w_obs, 6'b000010);
        end
        mc_clk_req = 1'b0;
        step();
        checks++;
        if (w_obs !== 6'b000000) begin
            errors++;
            $display("FAIL wd_idle: got %b want %b", w_obs, 6'b000000);
        end
        pulses(3, 2);
        checks++;
        if (w_obs !== 6'b000000) begin
            errors++;
            $display("FAIL wd_stay_idle: got %b want %b", w_obs, 6'b000000);
        end
    endtask

    task automatic test_same_cycle_drop();
        seq_on();
        checks++;
        if (w_obs !== 6'b110100) begin
            errors++;
            $display("FAIL sc_on: got %b want %b", w_obs, 6'b110100);
        end
        repeat (3) step();
        mc_clk_req  = 1'b0;
        pll_sync_in = 1'b1;
        step();
        pll_sync_in = 1'b0;
        checks++;
        if (w_obs !== 6'b010101) begin
            errors++;
            $display("FAIL sc_en_fall: got %b want %b", w_obs, 6'b010101);
        end
        step();
        step();
        checks++;
        if (w_obs !== 6'b000000) begin
            errors++;
            $display("FAIL sc_ack_fall: got %b want %b", w_obs, 6'b000000);
        end
    endtask

    task automatic test_reset_mid_drain();
        seq_on();
        mc_clk_req = 1'b0;
        step();
        step();
        checks++;
        if (w_obs !== 6'b110101) begin
            errors++;
            $display("FAIL rd_in_drain: got %b want %b", w_obs, 6'b110101);
        end
        #2 rst_b = 1'b0;
        #1;
        checks++;
        if (w_obs !== 6'b000000) begin
            errors++;
            $display("FAIL rd_async_clear: got %b want %b", w_obs, 6'b000000);
        end
        step();
        rst_b = 1'b1;
        step();
        checks++;
        if (w_obs !== 6'b000000) begin
            errors++;
            $display("FAIL rd_after_release: got %b want %b", w_obs, 6'b000000);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_enable();
        test_disable();
        test_timeout();
        test_lock_loss();
        test_withdraw();
        test_same_cycle_drop();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
